// File: rtl/iob_native_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : iob_native_mem_responder
// Purpose : IOb native-bus RAM target. Serves one request at a time and
//           returns a one-cycle ready pulse LATENCY cycles after capture.
// Config  : IOB_MEM_RESP_RANGE_CHK_EN adds out-of-range detection and the
//           sticky err port.
// Rev     : 1.0
// ============================================================================
module iob_native_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]     req,
  output logic [DATA_W:0]                     resp
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
  ,
  output logic                                err
`endif
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;

  assign valid = req[ADDR_W+DATA_W+STRB_W];
  assign addr  = req[ADDR_W+DATA_W+STRB_W-1 -: ADDR_W];
  assign wdata = req[DATA_W+STRB_W-1 -: DATA_W];
  assign wstrb = req[STRB_W-1:0];

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [MEM_ADDR_W-1:0] cap_idx;
  logic                  cap_wr;
  logic                  cap_oor;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];

  logic [MEM_ADDR_W-1:0] req_idx;
  logic                  req_wr;
  logic                  req_oor;
  logic                  capture;
  logic                  enter_resp;
  logic [MEM_ADDR_W-1:0] sel_idx;
  logic                  sel_wr;
  logic                  sel_oor;
  logic [DATA_W-1:0]     resp_data;
  logic                  unused_ok;

  assign req_idx = addr[MEM_ADDR_W+1:2];
  assign req_wr  = |wstrb;

`ifdef IOB_MEM_RESP_RANGE_CHK_EN
  localparam int REP_N = (DATA_W + 31) / 32;
  localparam logic [REP_N*32-1:0] DEAD_REP = {REP_N{32'hDEAD_BEEF}};

  assign req_oor   = |addr[ADDR_W-1:MEM_ADDR_W+2];
  assign unused_ok = ^addr[1:0];
`else
  assign req_oor   = 1'b0;
  assign unused_ok = ^{addr[ADDR_W-1:MEM_ADDR_W+2], addr[1:0]};
`endif

  assign capture = (state == ST_IDLE) && valid;

  // With LATENCY=1 the response is loaded at the capture edge itself, so the
  // source of the response fields is the live request rather than the capture.
  always_comb begin
    enter_resp = ((LATENCY == 1) && capture) || ((state == ST_WAIT) && (cnt == 4'd1));
    sel_idx    = (state == ST_IDLE) ? req_idx : cap_idx;
    sel_wr     = (state == ST_IDLE) ? req_wr  : cap_wr;
    sel_oor    = (state == ST_IDLE) ? req_oor : cap_oor;
    resp_data  = mem[sel_idx];
    if (sel_wr) begin
      resp_data = '0;
    end
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
    else if (sel_oor) begin
      resp_data = DEAD_REP[DATA_W-1:0];
    end
`endif
  end

  // RAM contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && capture && req_wr && !req_oor) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[req_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      cap_idx <= '0;
      cap_wr  <= 1'b0;
      cap_oor <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= enter_resp;
      if (enter_resp) begin
        rdata <= resp_data;
      end
      case (state)
        ST_IDLE: begin
          if (valid) begin
            cap_idx <= req_idx;
            cap_wr  <= req_wr;
            cap_oor <= req_oor;
            cnt     <= 4'(LATENCY - 1);
            state   <= (LATENCY > 1) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IOB_MEM_RESP_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (enter_resp && sel_oor) begin
      err <= 1'b1;
    end
  end
`endif

  assign resp = {rdata, ready};

endmodule
`default_nettype wire

// File: tb/tb_iob_native_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_iob_native_mem_responder
// Purpose : Randomized bench for iob_native_mem_responder at LATENCY 1 and 4
//           against an array-based memory model. Rev 1.0
// ============================================================================
module tb_iob_native_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, v4;
  logic [31:0] a1, a4, d1, d4;
  logic [3:0]  s1, s4;
  logic [68:0] req1, req4;
  logic [32:0] resp1, resp4;
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
  logic        err1, err4;
`endif

  assign req1 = {v1, a1, d1, s1};
  assign req4 = {v4, a4, d4, s4};

  always #5 clk = ~clk;

  iob_native_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk  (clk),
    .rst  (rst),
    .req  (req1),
    .resp (resp1)
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
    ,
    .err  (err1)
`endif
  );

  iob_native_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(4)) u_l4 (
    .clk  (clk),
    .rst  (rst),
    .req  (req4),
    .resp (resp4)
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
    ,
    .err  (err4)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [1024];
  logic        err_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic addr_oor(input logic [31:0] addr);
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
    return addr[31:12] != 20'd0;
`else
    return 1'b0;
`endif
  endfunction

  // One isolated transaction presented to both responders; ready must appear
  // exactly LATENCY cycles after capture and nowhere else in the window.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] exp;
    logic        oor;
    oor = addr_oor(addr);
    if (wstrb != 4'd0)  exp = 32'd0;
    else if (oor)       exp = 32'hDEAD_BEEF;
    else                exp = mem_m[addr[11:2]];
    if (!oor) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_m[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (oor) err_m = 1'b1;
    @(negedge clk);
    v1 = 1'b1; a1 = addr; d1 = wdata; s1 = wstrb;
    v4 = 1'b1; a4 = addr; d4 = wdata; s4 = wstrb;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        v1 = 1'b0;
        v4 = 1'b0;
      end
      check("ready_l1", {31'd0, resp1[0]}, {31'd0, (k == 1)});
      check("ready_l4", {31'd0, resp4[0]}, {31'd0, (k == 4)});
      if (k == 1) check("rdata_l1", resp1[32:1], exp);
      if (k == 4) check("rdata_l4", resp4[32:1], exp);
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
      if (k == 1) check("err_l1", {31'd0, err1}, {31'd0, err_m});
      if (k == 4) check("err_l4", {31'd0, err4}, {31'd0, err_m});
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [3];
    int          j;
    logic [31:0] ra;
    logic [3:0]  rs;

    // Reset held with a live request: nothing may be captured or answered.
    rst = 1'b1;
    v1 = 1'b1; a1 = 32'h40; d1 = 32'h5555_5555; s1 = 4'hF;
    v4 = 1'b1; a4 = 32'h40; d4 = 32'h5555_5555; s4 = 4'hF;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready_l1", {31'd0, resp1[0]}, 32'd0);
      check("rst_rdata_l1", resp1[32:1], 32'd0);
      check("rst_ready_l4", {31'd0, resp4[0]}, 32'd0);
      check("rst_rdata_l4", resp4[32:1], 32'd0);
`ifdef IOB_MEM_RESP_RANGE_CHK_EN
      check("rst_err_l1", {31'd0, err1}, 32'd0);
`endif
    end
    rst = 1'b0; v1 = 1'b0; v4 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready_l1", {31'd0, resp1[0]}, 32'd0);
      check("idle_ready_l4", {31'd0, resp4[0]}, 32'd0);
    end

    // Give the low 64 words known contents.
    for (int w = 0; w < 64; w++) begin
      do_txn(32'(w * 4), $urandom, 4'hF);
    end

    do_txn(32'h10, 32'h1234_5678, 4'hF);
    do_txn(32'h10, 32'h0, 4'h0);
    do_txn(32'h20, 32'hAABB_CCDD, 4'hF);
    do_txn(32'h20, 32'h1122_3344, 4'h5);
    do_txn(32'h20, 32'h0, 4'h0);
    check("strobe_model", mem_m[8], 32'hAA22_CC44);

    // Back-to-back reads with valid held high on the LATENCY=4 responder.
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h44;
    j = 0;
    @(negedge clk);
    v4 = 1'b1; a4 = addrs[0]; s4 = 4'h0; d4 = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("b2b_ready", {31'd0, resp4[0]}, {31'd0, (k == 4 || k == 9 || k == 14)});
      if (k == 4 || k == 9 || k == 14) begin
        check("b2b_rdata", resp4[32:1], mem_m[addrs[j][11:2]]);
        j++;
        if (j < 3) a4 = addrs[j];
        else       v4 = 1'b0;
      end
    end

    // Reset two cycles into a LATENCY=4 write: no response, write persists.
    mem_m[12] = 32'hCAFE_F00D;
    @(negedge clk);
    v1 = 1'b1; a1 = 32'h30; d1 = 32'hCAFE_F00D; s1 = 4'hF;
    v4 = 1'b1; a4 = 32'h30; d4 = 32'hCAFE_F00D; s4 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0;
    check("mrst_ready_l1", {31'd0, resp1[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_m = 1'b0;
    check("mrst_rdata_l4", resp4[32:1], 32'd0);
    for (int k = 3; k <= 8; k++) begin
      check("mrst_ready_l4", {31'd0, resp4[0]}, 32'd0);
      @(negedge clk);
    end
    do_txn(32'h30, 32'h0, 4'h0);

    // Upper address bits: aliasing in the default build, range error otherwise.
    do_txn(32'h1000, 32'h0BAD_F00D, 4'hF);
    do_txn(32'h0000, 32'h0, 4'h0);
    do_txn(32'h1000, 32'h0, 4'h0);

    for (int n = 0; n < 40; n++) begin
      ra = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0, 6'($urandom_range(0, 63)), 4'd0, 2'($urandom)};
      rs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_txn(ra, $urandom, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
